instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch                                                  |
// | Description : Single-outstanding instruction fetch unit. Issues a memory   |
// |               read at the PC, captures the returned word for decode,       |
// |               holds it under stall and redirects on branch.                |
// | Option      : FETCH_COUNT_EN - enables the saturating 16-bit accepted-     |
// |               fetch counter on fetch_count (tied to 0 otherwise).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              capture;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_out_q;

  // State register; reset returns to IDLE and abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request decode; a branch overrides everything and drops a
  // coincident ack so the redirected fetch is the only one that counts.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (branch_en) begin
      state_d = REQ;
      capture = 1'b0;
    end
  end

  // PC and instruction holding registers; the request address is the live PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
    end else if (branch_en) begin
      pc_q    <= branch_addr;
      valid_q <= 1'b0;
    end else if (capture) begin
      instr_q  <= mem_rdata;
      pc_out_q <= pc_q;
      pc_q     <= pc_q + PC_ONE;
      valid_q  <= 1'b1;
    end else if ((state_q == VALID) && !stall) begin
      valid_q <= 1'b0;
    end
  end

  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q;

  // Saturating count of captured instructions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else if (capture && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
`default_nettype wire
